uart_tx_sched: RTL
==================

# uart_tx_sched

Round-robin scheduler that shares one UART transmitter core (8 data bits, selectable parity, 1 stop bit) between several byte producers, such as the MIPS core and a debug port. It accepts one byte at a time over a valid/ready handshake and latches it with the parity mode sampled at that moment. It then drives the core through a start/busy handshake and enforces a programmable idle gap between frames. It sits between the requesters and the transmitter core; the baud tick generation stays inside the core.

## Interface
Parameters:
- `N_REQ`, default 2: number of requesters; legal range 2..8.
- `GAP_CYCLES`, default 16: `clk` cycles of forced idle after each frame; 0 means no gap.
- `START_TIMEOUT`, default 4096: `clk` cycles allowed for `tx_busy` to rise after `tx_start`.

Ports:
- `clk`  in  1: system clock, the same clock that feeds the baud generator.
- `rst`  in  1: reset; synchronous, active-high.
- `req_valid`  in  N_REQ: per-requester byte valid.
- `req_data`  in  8*N_REQ: requester i owns bits [8i+7:8i].
- `req_ready`  out  N_REQ: one-hot accept; at most one bit high.
- `parity_sel`  in  1: 0 = even parity, 1 = odd parity.
- `tx_busy`  in  1: core is shifting a frame.
- `tx_start`  out  1: one-cycle launch pulse to the core.
- `tx_data`  out  8: byte presented to the core.
- `tx_parity`  out  1: parity mode for the current frame.
- `grant_id`  out  $clog2(N_REQ): index of the last accepted requester.
- `sched_busy`  out  1: high in every state except IDLE.
- `err_timeout`  out  1: one-cycle pulse when the core failed to start.

## Operation
State machine IDLE → START → WAIT_BUSY → SENDING → GAP → IDLE.

- **IDLE**
  - Winner: the first requester with valid high, scanning upward from `rr_ptr` and wrapping.
  - `req_ready[winner]` = 1 combinationally, in the same cycle.
  - On the accept: latch `req_data` slice into `tx_data`, latch `parity_sel` into `tx_parity`, set `grant_id` = winner, set `rr_ptr` = (winner+1) mod N_REQ, go to START.
  - No valid requester: stay in IDLE, `req_ready` = 0.
- **START**
  - `tx_start` = 1 for exactly this one cycle.
  - Clear the timeout counter, go to WAIT_BUSY.
- **WAIT_BUSY**
  - `tx_busy` = 1: go to SENDING.
  - Otherwise increment the counter.
  - Counter reaches START_TIMEOUT−1 with `tx_busy` still 0: pulse `err_timeout` and go to GAP. The byte is dropped and not retried.
- **SENDING**: wait for `tx_busy` = 0, then go to GAP.
- **GAP**
  - Count GAP_CYCLES cycles, then go to IDLE.
  - GAP_CYCLES = 0: GAP lasts zero cycles; the transition that would enter GAP goes directly to IDLE.

Rules:
- Requesters must hold `req_valid` and `req_data` stable until ready.
- `req_valid` may drop without penalty when not granted.
- `tx_data` and `tx_parity` stay constant from accept until the next accept.
- `parity_sel` changes during a frame have no effect on that frame.
- Reset, from any state including mid-frame:
  - state = IDLE, `rr_ptr` = 0, all counters = 0.
  - `tx_start` = 0, `tx_data` = 8'h00, `tx_parity` = 0, `grant_id` = 0, `err_timeout` = 0, `req_ready` = 0 during the reset cycle.
  - An in-flight core frame is not aborted; the next START waits normally.
- Counter widths: `$clog2` of the larger of GAP_CYCLES and START_TIMEOUT, plus 1 bit. No wrap is reachable.

## Timing
- Accept in cycle T:
  - `tx_start` high in T+1.
  - Earliest `tx_busy` sample in T+2.
- Minimum spacing between two accepts = 3 + (busy rise latency) + (frame length in clk) + GAP_CYCLES.
- Back-to-back requesters alternate strictly under round-robin; no requester waits more than N_REQ−1 grants.
- `tx_busy` already high on entry to WAIT_BUSY (core still busy from before reset) is treated as this frame's start. This is accepted behaviour.
- All outputs except `req_ready` are registered.

## Structure
- Shared package `uart_pkg`:
  - state enum `sched_state_t` (IDLE, START, WAIT_BUSY, SENDING, GAP).
  - constants `PARITY_EVEN` = 0, `PARITY_ODD` = 1.
- One sub-module `rr_arbiter` (parameter N): inputs `req` and `ptr`, outputs one-hot `grant` and encoded `grant_idx`; purely combinational.
- FSM, counters and latches live in `uart_tx_sched`.

## Test plan
- Single request: N_REQ=2, requester 0 sends 8'hA5 with parity_sel=1 → `tx_start` pulse one cycle after accept, `tx_data`=A5, `tx_parity`=1, `grant_id`=0.
- Contention: both requesters valid continuously with bytes 8'h11 and 8'h22 → frames alternate 11, 22, 11, 22; first grant goes to 0 after reset.
- Core model never raises busy, START_TIMEOUT=8 → `err_timeout` pulses exactly 8 cycles after WAIT_BUSY entry; next accept occurs after GAP.
- Gap check, GAP_CYCLES=16 → no `req_ready` until 16 cycles after `tx_busy` falls; with GAP_CYCLES=0, ready is offered the cycle after busy falls.
- Reset asserted in SENDING → next cycle `sched_busy`=0, `tx_start`=0, `rr_ptr`=0; following request is served from requester 0.
- `parity_sel` toggled while in SENDING → `tx_parity` unchanged until the next accept.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit scheduler.
//   sched_state_t : scheduler FSM states
//   PARITY_EVEN / PARITY_ODD : encodings of parity_sel / tx_parity
//   max_int()     : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        SENDING   = 3'd3,
        GAP       = 3'd4
    } sched_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted req scanning
// upward from ptr, wrapping at N.
// Ports:
//   req       in  N          request vector
//   ptr       in  $clog2(N)  highest-priority index (must be < N)
//   grant     out N          one-hot winner, all zero when no request
//   grant_idx out $clog2(N)  encoded winner, 0 when no request
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // NOTE: every signal driven here gets a default at the top of the block;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            // One extra bit keeps ptr + k from overflowing before the wrap.
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
// Round-robin scheduler sharing one UART transmitter core between N_REQ byte
// producers. Accepts one byte over valid/ready, launches it with a one-cycle
// tx_start, tracks the core's busy flag, and enforces an idle gap per frame.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req_valid/req_data per-requester byte offer (requester i = bits [8i+7:8i])
//   req_ready          one-hot combinational accept
//   parity_sel         parity mode sampled at accept (0 even, 1 odd)
//   tx_busy            core busy flag
//   tx_start           one-cycle launch pulse
//   tx_data/tx_parity  latched byte and parity mode for the core
//   grant_id           index of the last accepted requester
//   sched_busy         high whenever the FSM is not IDLE
//   err_timeout        one-cycle pulse when the core never raised tx_busy
// -----------------------------------------------------------------------------
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int N_REQ         = 2,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     parity_sel,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic                     tx_parity,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     sched_busy,
    output logic                     err_timeout
);

    localparam int IW    = $clog2(N_REQ);
    localparam int CNT_W = $clog2(max_int(GAP_CYCLES, START_TIMEOUT)) + 1;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    // With no gap configured the end of a frame returns straight to IDLE.
    localparam sched_state_t     AFTER_FRAME  = (GAP_CYCLES == 0) ? IDLE : GAP;
    localparam logic [IW-1:0]    LAST_REQ     = IW'(N_REQ - 1);

    sched_state_t     state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [IW-1:0]    rr_ptr;
    logic [N_REQ-1:0] grant;
    logic [IW-1:0]    win_idx;
    logic             any_grant;
    logic             accept;
    logic             timed_out;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (win_idx)
    );

    assign any_grant = |grant;
    assign accept    = (state == IDLE) && any_grant;
    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign timed_out = (state == WAIT_BUSY) && !tx_busy && (cnt == TIMEOUT_LAST);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: begin
                if (any_grant) state_d = START;
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                // A core already busy on entry is taken as this frame's start.
                if (tx_busy) begin
                    state_d = SENDING;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_d   = '0;
                    state_d = AFTER_FRAME;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SENDING: begin
                if (!tx_busy) begin
                    cnt_d   = '0;
                    state_d = AFTER_FRAME;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            tx_parity   <= PARITY_EVEN;
            grant_id    <= '0;
            sched_busy  <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            sched_busy  <= (state_d != IDLE);
            tx_start    <= accept;
            err_timeout <= timed_out;
            if (accept) begin
                tx_data   <= req_data[{win_idx, 3'b000} +: 8];
                tx_parity <= (parity_sel == PARITY_ODD) ? PARITY_ODD : PARITY_EVEN;
                grant_id  <= win_idx;
                rr_ptr    <= (win_idx == LAST_REQ) ? '0 : win_idx + 1'b1;
            end
        end
    end

endmodule
